// File: rtl/alu16_arbiter.sv
// alu16_arbiter: round-robin arbiter sharing one ALU16 between two
// requesters. A four-state FSM (IDLE, ISSUE, WAIT, DONE) grants one
// requester, issues its operation, waits for completion under a 6-bit
// watchdog and returns the result with a one-cycle done pulse.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req0/req1         operation requests, held until done
//   op0/op1           op select (0 ADD, 1 SUB, 2 MUL, 3 DIV, others invalid)
//   x0/y0, x1/y1      16-bit operands per requester
//   alu_s/x/y         latched op and operands towards the ALU16
//   alu_start         one-cycle start pulse to the ALU16
//   alu_finish        completion pulse from the ALU16
//   alu_res           ALU16 result {hi, lo}, valid with alu_finish
//   grant             one-hot current owner, 00 when idle
//   done0/done1       one-cycle completion pulse per requester
//   res, err          result and error of the last completed operation
//   busy              high whenever the FSM is not in IDLE
module alu16_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  output logic [3:0]  alu_s,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_start,
  input  logic        alu_finish,
  input  logic [31:0] alu_res,
  output logic [1:0]  grant,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic        ptr;
  logic [5:0]  wd;

  logic        win1;
  logic [3:0]  sel_op;
  logic [15:0] sel_x;
  logic [15:0] sel_y;
  logic        sel_ok;

  // Requester 1 wins when it is the only one asking, or when both
  // ask and the pointer favours it.
  assign win1   = req1 & (~req0 | ptr);
  assign sel_op = win1 ? op1 : op0;
  assign sel_x  = win1 ? x1  : x0;
  assign sel_y  = win1 ? y1  : y0;
  assign sel_ok = (sel_op[3:2] == 2'b00);

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      wd        <= 6'd0;
      grant     <= 2'b00;
      alu_start <= 1'b0;
      alu_s     <= 4'd0;
      alu_x     <= 16'd0;
      alu_y     <= 16'd0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res       <= 32'd0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= win1 ? 2'b10 : 2'b01;
            alu_s <= sel_op;
            alu_x <= sel_x;
            alu_y <= sel_y;
            if (sel_ok) begin
              alu_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              // Invalid op never reaches the ALU; res is kept.
              err   <= 1'b1;
              done0 <= ~win1;
              done1 <= win1;
              state <= DONE;
            end
          end
        end

        ISSUE: begin
          alu_start <= 1'b0;
          wd        <= 6'd0;
          state     <= WAIT;
        end

        WAIT: begin
          // A finish in the same cycle as the timeout still wins.
          if (alu_finish) begin
            res   <= alu_res;
            err   <= 1'b0;
            done0 <= grant[0];
            done1 <= grant[1];
            state <= DONE;
          end else if (wd == 6'd63) begin
            res   <= 32'd0;
            err   <= 1'b1;
            done0 <= grant[0];
            done1 <= grant[1];
            state <= DONE;
          end else begin
            wd <= wd + 6'd1;
          end
        end

        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          // Next tie goes to the requester that was not just served.
          ptr   <= grant[0];
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_arbiter.sv
// tb_alu16_arbiter: vector table plus scoreboard bench for alu16_arbiter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_alu16_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [15:0] x0, y0, x1, y1;
  logic [3:0]  alu_s;
  logic [15:0] alu_x, alu_y;
  logic        alu_start;
  logic        alu_finish;
  logic [31:0] alu_res;
  logic [1:0]  grant;
  logic        done0, done1;
  logic [31:0] res;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  alu16_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y),
    .alu_start(alu_start), .alu_finish(alu_finish),
    .alu_res(alu_res), .grant(grant),
    .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy)
  );

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] res;
    logic        err;
    int          done_c;
    int          nstart;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = 32'd0;
  logic        ptr_m = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(logic [3:0] op,
                                            logic [15:0] x,
                                            logic [15:0] y);
    case (op)
      4'd0: return 32'(x) + 32'(y);
      4'd1: return 32'(x) - 32'(y);
      4'd2: return 32'(x) * 32'(y);
      4'd3: return (y == 16'd0) ? 32'hFFFF_FFFF : {x % y, x / y};
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive_req(logic who, logic on, logic [3:0] op,
                           logic [15:0] x, logic [15:0] y);
    if (!who) begin
      req0 = on; op0 = op; x0 = x; y0 = y;
    end else begin
      req1 = on; op1 = op; x1 = x; y1 = y;
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_alu_s"}, 32'(alu_s), 32'd0);
    chk({tag, "_alu_xy"}, {alu_x, alu_y}, 32'd0);
    chk({tag, "_done"}, 32'({done1, done0}), 32'd0);
    chk({tag, "_res"}, res, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(vec_t v);
    exp_t        e;
    logic [31:0] mr;
    int          start_c;
    bit          got;
    mr = alu_model(v.op, v.x, v.y);
    e.grant = v.who ? 2'b10 : 2'b01;
    if (v.op >= 4'd4) begin
      e.res = last_res; e.err = 1'b1; e.nstart = 0; e.done_c = 1;
    end else if (v.lat < 0) begin
      e.res = 32'd0; e.err = 1'b1; e.nstart = 1; e.done_c = 66;
    end else begin
      e.res = mr; e.err = 1'b0; e.nstart = 1; e.done_c = v.lat + 2;
    end
    sbq.push_back(e);
    @(negedge clk);
    drive_req(v.who, 1'b1, v.op, v.x, v.y);
    alu_res = mr;
    start_c = -1;
    got = 0;
    e.nstart = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      if (alu_start) begin
        e.nstart++;
        start_c = c;
        chk("start_lat", 32'(c), 32'd1);
        chk("issue_op", 32'(alu_s), 32'(v.op));
        chk("issue_xy", {alu_x, alu_y}, {v.x, v.y});
      end
      if (done0 | done1) begin
        exp_t x;
        got = 1;
        x = sbq.pop_front();
        chk("done_grant", 32'(grant), 32'(x.grant));
        chk("done_line", 32'({done1, done0}), 32'(x.grant));
        chk("done_res", res, x.res);
        chk("done_err", 32'(err), 32'(x.err));
        chk("done_lat", 32'(c), 32'(x.done_c));
        chk("start_cnt", 32'(e.nstart), 32'(x.nstart));
        drive_req(v.who, 1'b0, 4'd0, 16'd0, 16'd0);
        last_res = x.res;
        ptr_m = ~v.who;
      end else if (start_c > 0 && v.lat >= 0 && c == start_c + v.lat) begin
        alu_finish = 1'b1;
      end
      // Idle requester's operands must not matter.
      if (!got) begin
        if (v.who) begin
          x0 = 16'($urandom); y0 = 16'($urandom);
        end else begin
          x1 = 16'($urandom); y1 = 16'($urandom);
        end
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL vec_timeout actual=no_done required=done");
    end
    alu_finish = 1'b0;
    @(negedge clk);
    chk("after_grant", 32'(grant), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_pair();
    exp_t e;
    logic first;
    int   nst, ndone, d0, d1, sc;
    first = ptr_m;
    for (int k = 0; k < 2; k++) begin
      logic w;
      w = (k == 0) ? first : ~first;
      e.grant = w ? 2'b10 : 2'b01;
      e.res = w ? alu_model(4'd2, 16'd123, 16'd45)
                : alu_model(4'd2, 16'd40, 16'd6);
      e.err = 1'b0; e.done_c = 0; e.nstart = 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    drive_req(1'b0, 1'b1, 4'd2, 16'd40, 16'd6);
    drive_req(1'b1, 1'b1, 4'd2, 16'd123, 16'd45);
    nst = 0; ndone = 0; d0 = 0; d1 = 0; sc = -1;
    for (int c = 1; c <= 400 && ndone < 2; c++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      if (alu_start) begin
        chk("pair_overlap", 32'(nst - ndone), 32'd0);
        nst++;
        sc = c;
        alu_res = alu_model(alu_s, alu_x, alu_y);
      end
      if (done0 | done1) begin
        e = sbq.pop_front();
        chk("pair_grant", 32'(grant), 32'(e.grant));
        chk("pair_res", res, e.res);
        chk("pair_err", 32'(err), 32'(e.err));
        ndone++;
        if (done0) begin d0++; req0 = 1'b0; ptr_m = 1'b1; end
        if (done1) begin d1++; req1 = 1'b0; ptr_m = 1'b0; end
        last_res = res;
      end else if (sc > 0 && c == sc + 2) begin
        alu_finish = 1'b1;
      end
    end
    if (ndone < 2) begin
      checks++; failures++;
      $display("FAIL pair_timeout actual=%0d required=2", ndone);
    end
    alu_finish = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    chk("pair_starts", 32'(nst), 32'd2);
    chk("pair_done0", 32'(d0), 32'd1);
    chk("pair_done1", 32'(d1), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_reset_in_wait();
    int nd;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 4'd1, 16'd77, 16'd11);
    repeat (4) @(negedge clk);
    chk("rw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    alu_finish = 1'b1;
    alu_res = 32'hDEAD_BEEF;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      alu_finish = 1'b0;
      if (done0 | done1) nd++;
    end
    chk("rw_no_done", 32'(nd), 32'd0);
    chk_reset_vals("rw");
    last_res = 32'd0;
    ptr_m = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 4'd0; op1 = 4'd0;
    x0 = 16'd0; y0 = 16'd0; x1 = 16'd0; y1 = 16'd0;
    alu_finish = 1'b0;
    alu_res = 32'd0;

    vecs[0] = '{who: 1'b0, op: 4'd0,  x: 16'd5,    y: 16'd3,    lat: 4};
    vecs[1] = '{who: 1'b1, op: 4'd1,  x: 16'd100,  y: 16'd30,   lat: 1};
    vecs[2] = '{who: 1'b0, op: 4'd2,  x: 16'd300,  y: 16'd500,  lat: 7};
    vecs[3] = '{who: 1'b1, op: 4'd3,  x: 16'd1000, y: 16'd7,    lat: 3};
    vecs[4] = '{who: 1'b1, op: 4'd9,  x: 16'd1,    y: 16'd2,    lat: 0};
    vecs[5] = '{who: 1'b0, op: 4'd15, x: 16'd3,    y: 16'd4,    lat: 0};
    vecs[6] = '{who: 1'b0, op: 4'd0,  x: 16'd12,   y: 16'd34,   lat: -1};
    vecs[7] = '{who: 1'b1, op: 4'd2,  x: 16'hFFFF, y: 16'hFFFF, lat: 64};
    vecs[8] = '{who: 1'b0, op: 4'd3,  x: 16'd9,    y: 16'd0,    lat: 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst");

    run_pair();
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    run_pair();
    run_reset_in_wait();
    run_pair();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
